// File: rtl/dense_chain_pkg.sv
// Shared types and helpers for the dense-layer chain engine.
// DENSE_CHAIN_SAT_EN selects saturating (defined) or wrapping (undefined) narrowing.
package dense_chain_pkg;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_IDLE,
      ST_RUN,
      ST_OUT
   } state_t;

   function automatic int fan_max(input int num_in, input int num_nerves);
      return (num_in > num_nerves) ? num_in : num_nerves;
   endfunction

   function automatic int acc_width(input int bit_size, input int w_bit_size, input int fan);
      return bit_size + w_bit_size + $clog2(fan);
   endfunction

   // Result is sign-extended to 64 bits; the caller keeps the low `bits` bits.
   function automatic logic signed [63:0] narrow_val(input logic signed [63:0] v, input int bits);
`ifdef DENSE_CHAIN_SAT_EN
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (bits - 1));
      if (v > max_v) return max_v;
      else if (v < min_v) return min_v;
      else return v;
`else
      return (v <<< (64 - bits)) >>> (64 - bits);
`endif
   endfunction

endpackage

// File: rtl/dense_dot.sv
// One neuron: signed multiply-accumulate across FanMax lanes, shift, narrow, optional ReLU.
module dense_dot
   import dense_chain_pkg::*;
#(
   parameter int BitSize   = 8,
   parameter int W_BitSize = 4,
   parameter int FanMax    = 4,
   parameter int FracShift = 0
) (
   input  logic [FanMax-1:0][BitSize-1:0]   act,
   input  logic [FanMax-1:0][W_BitSize-1:0] wgt,
   input  logic                             relu,
   output logic [BitSize-1:0]               res
);

   localparam int AccW = acc_width(BitSize, W_BitSize, FanMax);

   logic signed [AccW-1:0] acc;
   logic signed [AccW-1:0] acc_sh;
   logic signed [AccW-1:0] a_x;
   logic signed [AccW-1:0] w_x;
   logic signed [BitSize-1:0] nar;

   // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
   always_comb begin
      acc = '0;
      a_x = '0;
      w_x = '0;
      for (int i = 0; i < FanMax; i++) begin
         a_x = AccW'($signed(act[i]));
         w_x = AccW'($signed(wgt[i]));
         acc = acc + a_x * w_x;
      end
      acc_sh = acc >>> FracShift;
      nar    = BitSize'(narrow_val(64'(acc_sh), BitSize));
      res    = (relu && nar[BitSize-1]) ? '0 : nar;
   end

endmodule

// File: rtl/dense_chain_engine.sv
// Weight-stationary chain of dense layers, one neuron per clock, ping-pong activations.
// Optional macro DENSE_CHAIN_SAT_EN: saturate instead of wrap when narrowing results.
module dense_chain_engine
   import dense_chain_pkg::*;
#(
   parameter int BitSize   = 8,
   parameter int W_BitSize = 4,
   parameter int NumIn     = 4,
   parameter int NumNerves = 4,
   parameter int NumLayers = 2,
   parameter int FracShift = 0
) (
   input  logic                                                clk,
   input  logic                                                res_n,
   input  logic                                                in_w_valid,
   input  logic [fan_max(NumIn, NumNerves)-1:0][W_BitSize-1:0] in_weights,
   input  logic                                                in_w_reload,
   input  logic                                                in_valid,
   input  logic [NumIn-1:0][BitSize-1:0]                       in_data,
   output logic                                                in_ready,
   input  logic [NumLayers-1:0]                                in_relu,
   output logic                                                out_valid,
   output logic [NumNerves-1:0][BitSize-1:0]                   out_data,
   input  logic                                                out_ready,
   output logic                                                w_loaded
);

   localparam int FanMax  = fan_max(NumIn, NumNerves);
   localparam int TotRows = NumLayers * NumNerves;
   localparam int RowW    = (TotRows > 1) ? $clog2(TotRows) : 1;
   localparam int NW      = (FanMax > 1) ? $clog2(FanMax) : 1;
   localparam int LW      = (NumLayers > 1) ? $clog2(NumLayers) : 1;

   state_t state, state_nxt;
   logic [RowW-1:0]      row;
   logic [NW-1:0]        nrn;
   logic [LW-1:0]        lyr;
   logic                 sel;
   logic [NumLayers-1:0] relu_q;

   logic [FanMax-1:0][W_BitSize-1:0] wmem [TotRows];
   logic [FanMax-1:0][BitSize-1:0]   act  [2];
   logic [FanMax-1:0][W_BitSize-1:0] w_row;
   logic [FanMax-1:0][BitSize-1:0]   act_in;
   logic [BitSize-1:0]               dot_res;

   logic last_row, last_nrn, last_lyr;
   assign last_row = (row == RowW'(TotRows - 1));
   assign last_nrn = (nrn == NW'(NumNerves - 1));
   assign last_lyr = (lyr == LW'(NumLayers - 1));

   // Lanes beyond a layer's fan-in are stored as zero so they never contribute.
   always_comb begin
      int lim;
      lim    = (row < RowW'(NumNerves)) ? NumIn : NumNerves;
      w_row  = in_weights;
      act_in = '0;
      act_in[NumIn-1:0] = in_data;
      for (int i = 0; i < FanMax; i++)
         if (i >= lim) w_row[i] = '0;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_OUT);
      case (state)
         ST_LOAD: if (!in_w_reload && in_w_valid && last_row) state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (in_w_reload)   state_nxt = ST_LOAD;
            else if (in_valid) state_nxt = ST_RUN;
         end
         ST_RUN:  if (last_nrn && last_lyr) state_nxt = ST_OUT;
         ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_LOAD;
      endcase
   end

   // NOTE: weight storage has no reset; a full reload always precedes its use.
   always_ff @(posedge clk)
      if (state == ST_LOAD && in_w_valid && !in_w_reload) wmem[row] <= w_row;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state    <= ST_LOAD;
         row      <= '0;
         nrn      <= '0;
         lyr      <= '0;
         sel      <= 1'b0;
         relu_q   <= '0;
         w_loaded <= 1'b0;
         out_data <= '0;
         act[0]   <= '0;
         act[1]   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_LOAD: begin
               if (in_w_reload) row <= '0;
               else if (in_w_valid) begin
                  row <= last_row ? '0 : row + 1'b1;
                  if (last_row) w_loaded <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (in_w_reload) begin
                  w_loaded <= 1'b0;
                  row      <= '0;
               end else if (in_valid) begin
                  act[0] <= act_in;
                  sel    <= 1'b0;
                  relu_q <= in_relu;
                  row    <= '0;
                  nrn    <= '0;
                  lyr    <= '0;
               end
            end
            ST_RUN: begin
               act[!sel][nrn] <= dot_res;
               if (last_lyr) out_data[nrn] <= dot_res;
               row <= last_row ? '0 : row + 1'b1;
               if (last_nrn) begin
                  nrn <= '0;
                  lyr <= lyr + 1'b1;
                  sel <= !sel;
               end else begin
                  nrn <= nrn + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   dense_dot #(
      .BitSize  (BitSize),
      .W_BitSize(W_BitSize),
      .FanMax   (FanMax),
      .FracShift(FracShift)
   ) u_dot (
      .act (act[sel]),
      .wgt (wmem[row]),
      .relu(relu_q[lyr]),
      .res (dot_res)
   );

endmodule

// File: doc/dense_chain_engine.md
DENSE_CHAIN_ENGINE -- requirements
Module: dense_chain_engine

Interface
REQ-001 SHALL have parameter BitSize, default 8, signed activation width.
REQ-002 SHALL have parameter W_BitSize, default 4, signed weight width.
REQ-003 SHALL have parameter NumIn, default 4, layer-0 fan-in.
REQ-004 SHALL have parameter NumNerves, default 4, neurons per layer; fan-in of layers 1..NumLayers-1.
REQ-005 SHALL have parameter NumLayers, default 2, dense layers in chain.
REQ-006 SHALL have parameter FracShift, default 0, arithmetic right shift applied to each accumulator.
REQ-007 SHALL have ports clk input 1 (clock) and res_n input 1 (reset); one clock; reset is asynchronous and active-low.
REQ-008 SHALL have in_w_valid input 1, weight beat strobe; in_weights input FanMax x W_BitSize, one neuron row per beat, FanMax = max(NumIn,NumNerves).
REQ-009 SHALL have in_w_reload input 1, request return to weight loading.
REQ-010 SHALL have in_valid input 1, in_data input NumIn x BitSize, in_ready output 1.
REQ-011 SHALL have in_relu input NumLayers, per-layer ReLU enable, sampled at input acceptance.
REQ-012 SHALL have out_valid output 1, out_data output NumNerves x BitSize, out_ready input 1.
REQ-013 SHALL have w_loaded output 1, high when full weight set is held.

Function
REQ-014 SHALL implement FSM LOAD, IDLE, RUN, OUT; reset state LOAD.
REQ-015 LOAD: each in_w_valid beat SHALL store one row, order layer 0 neuron 0 .. layer NumLayers-1 neuron NumNerves-1; lanes at index >= layer fan-in ignored.
REQ-016 After beat NumLayers*NumNerves SHALL enter IDLE and set w_loaded the next cycle; in_w_valid outside LOAD ignored.
REQ-017 in_ready SHALL equal (state==IDLE); in_valid&&in_ready SHALL capture in_data and in_relu, enter RUN.
REQ-018 RUN SHALL compute exactly one neuron per cycle, layer-major, neuron-minor, NumLayers*NumNerves cycles, ping-pong activation buffers swapped at each layer end.
REQ-019 Neuron result: signed sum of products over fan-in, accumulator width BitSize+W_BitSize+clog2(FanMax), then >>> FracShift, then narrowed to BitSize, then ReLU (negative -> 0) if that layer's captured enable bit set.
REQ-020 After last RUN cycle SHALL enter OUT: out_valid=1, out_data=final layer, both stable until out_ready.
REQ-021 out_valid SHALL rise NumLayers*NumNerves+1 cycles after the acceptance cycle (9 at defaults).
REQ-022 out_valid&&out_ready SHALL return to IDLE; in_ready rises next cycle (no same-cycle accept).
REQ-023 in_w_reload in IDLE SHALL enter LOAD, clear w_loaded and row counter; ignored in RUN/OUT; in LOAD restarts row counter to 0.
REQ-024 in_valid during LOAD/RUN/OUT SHALL be ignored (in_ready low).

Reset
REQ-025 res_n low SHALL asynchronously force LOAD, counters 0, in_ready=0, out_valid=0, w_loaded=0, out_data=0; weight storage need not clear.
REQ-026 Reset mid-RUN/OUT SHALL discard the operation; weights reload required.

Configuration
REQ-027 Macro DENSE_CHAIN_SAT_EN defined: narrowing SHALL saturate to [-2^(BitSize-1), 2^(BitSize-1)-1].
REQ-028 Macro undefined: narrowing SHALL keep low BitSize bits (two's-complement wrap).

Structure
REQ-029 Package dense_chain_pkg SHALL hold FSM state enum, FanMax/accumulator-width functions, saturate/wrap function.
REQ-030 Sub-module dense_dot SHALL hold the combinational FanMax-lane multiply-accumulate, shift and narrow.

Verification (defaults, FracShift 0)
REQ-031 Identity weights both layers, in_data {1,2,3,4}, relu 00 -> out_data {1,2,3,4}, out_valid 9 cycles after accept.
REQ-032 All weights 1, in {1,2,3,4} -> layer0 all 10, out_data all 40.
REQ-033 Layer0 all 7, layer1 identity, in all 127 -> out all 127 with DENSE_CHAIN_SAT_EN, all -28 without.
REQ-034 Layer0 all -1, layer1 identity, in {1,2,3,4}, relu=10 -> out all 0; relu=00 -> all -10.
REQ-035 out_ready held low 5 cycles -> out_valid, out_data stable, in_ready low; release -> in_ready high next cycle.
REQ-036 res_n pulsed mid-RUN -> out_valid 0, w_loaded 0, state LOAD; in_w_reload during RUN -> no effect.
